// File: rtl/aes_pkg.sv
// Shared AES types, sizes and byte helpers.
// Byte 0 of a state is its most significant byte (FIPS-197 order).
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    localparam int AES_NB_BYTES = 16;

    // Extract byte i of a state, byte 0 being bits [127:120].
    function automatic byte_t get_byte(state_t s, int i);
        state_t sh;
        sh = s >> (8 * (AES_NB_BYTES - 1 - i));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/sbox_sync.sv
// AES forward S-box with a registered read port.
// Lookup data appears on y one clock after the address is presented.
module sbox_sync
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] a,
    output logic [7:0] y
);

    byte_t y_q;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic byte_t gmul(byte_t x, byte_t z);
        byte_t p;
        byte_t aa;
        byte_t bb;
        p  = '0;
        aa = x;
        bb = z;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic byte_t ginv(byte_t x);
        byte_t r;
        byte_t sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    // Inverse followed by the FIPS-197 affine transform.
    function automatic byte_t sbox_f(byte_t x);
        byte_t b;
        b = ginv(x);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

    // Registered read: one cycle from address to data.
    always_ff @(posedge clk) begin
        y_q <= sbox_f(a);
    end

    assign y = y_q;

endmodule

// File: rtl/sub_bytes_seq.sv
// AES SubBytes over a 128-bit state, streamed through NUM_SBOX lanes.
// The S-box read latency is hidden behind a start/done handshake.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out
);

    localparam int B  = AES_NB_BYTES / NUM_SBOX;
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fsm_e;

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
        NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
        $error("sub_bytes_seq: illegal NUM_SBOX %0d", NUM_SBOX);
    end

    fsm_e          fsm_q,  fsm_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    state_t        in_q,   in_d;
    state_t        work_q, work_d;
    state_t        out_q,  out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    byte_t addr [NUM_SBOX];
    byte_t y    [NUM_SBOX];

    logic cap;
    int   beat;

    // Lanes read only while issuing; address idles at zero otherwise.
    always_comb begin
        for (int j = 0; j < NUM_SBOX; j++) begin
            addr[j] = '0;
            if (fsm_q == ISSUE) begin
                addr[j] = get_byte(in_q, int'(cnt_q) * NUM_SBOX + j);
            end
        end
    end

    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
        sbox_sync u_sbox (
            .clk (clk),
            .a   (addr[j]),
            .y   (y[j])
        );
    end

    // Next-state: sequencing, beat capture and result commit.
    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        in_d   = in_q;
        work_d = work_q;
        out_d  = out_q;
        cap    = 1'b0;
        beat   = 0;
        unique case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    in_d  = state_in;
                    cnt_d = '0;
                    fsm_d = ISSUE;
                end else begin
                    fsm_d = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_q != '0) begin
                    cap  = 1'b1;
                    beat = int'(cnt_q) - 1;
                end
                if (int'(cnt_q) == B - 1) begin
                    fsm_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                cap   = 1'b1;
                beat  = B - 1;
                fsm_d = DONE;
            end
            default: fsm_d = IDLE;
        endcase
        if (cap) begin
            for (int j = 0; j < NUM_SBOX; j++) begin
                work_d[127 - 8 * (beat * NUM_SBOX + j) -: 8] = y[j];
            end
        end
        if (fsm_q == DRAIN) begin
            out_d = work_d;
        end
        busy_d = (fsm_d == ISSUE) || (fsm_d == DRAIN);
        done_d = (fsm_d == DONE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            in_q   <= '0;
            work_q <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            in_q   <= in_d;
            work_q <= work_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Randomised bench for sub_bytes_seq at 1, 4 and 16 lanes.
// Reference is a FIPS-197 S-box table applied byte by byte.
module tb_sub_bytes_seq;

    localparam logic [0:2047] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] C1_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] C2_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] C2_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    localparam int BEATS [3] = '{16, 4, 1};

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   st;
    logic [127:0] sin;
    logic [2:0]   busy_w;
    logic [2:0]   done_w;
    logic [127:0] so_w [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_bytes_seq #(.NUM_SBOX(1)) u_n1 (
        .clk(clk), .reset(reset), .start(st[0]), .state_in(sin),
        .busy(busy_w[0]), .done(done_w[0]), .state_out(so_w[0])
    );
    sub_bytes_seq #(.NUM_SBOX(4)) u_n4 (
        .clk(clk), .reset(reset), .start(st[1]), .state_in(sin),
        .busy(busy_w[1]), .done(done_w[1]), .state_out(so_w[1])
    );
    sub_bytes_seq #(.NUM_SBOX(16)) u_n16 (
        .clk(clk), .reset(reset), .start(st[2]), .state_in(sin),
        .busy(busy_w[2]), .done(done_w[2]), .state_out(so_w[2])
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = s[127 - 8 * i -: 8];
            r[127 - 8 * i -: 8] = SBOX_T[int'(b) * 8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_op(input int k, input logic [127:0] s,
                          input bit noise);
        int b;
        int cyc;
        int bad;
        int extra;
        b = BEATS[k];
        @(negedge clk);
        sin   = s;
        st[k] = 1'b1;
        @(posedge clk); #1;
        st[k] = 1'b0;
        if (noise) sin = rand128();
        check($sformatf("busy_on%0d", k), 128'(busy_w[k]), 128'd1);
        cyc = 0;
        bad = 0;
        while (!done_w[k] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc <= b && !busy_w[k]) bad++;
            if (noise) begin
                sin   = rand128();
                st[k] = (cyc < b) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        st[k] = 1'b0;
        check($sformatf("lat%0d", k), 128'(cyc), 128'(b + 1));
        check($sformatf("res%0d", k), so_w[k], ref_sub(s));
        check($sformatf("busy_hold%0d", k), 128'(bad), 128'd0);
        if (noise) begin
            extra = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (done_w[k]) extra++;
            end
            check("noise_pulses", 128'(extra), 128'd0);
            check("noise_idle", 128'(busy_w[k]), 128'd0);
            check("noise_res", so_w[k], ref_sub(s));
        end
    endtask

    task automatic b2b(input int k, input logic [127:0] s1,
                       input logic [127:0] s2);
        int b;
        int cyc;
        int held;
        b = BEATS[k];
        @(negedge clk);
        sin   = s1;
        st[k] = 1'b1;
        @(posedge clk); #1;
        sin = s2;
        cyc = 0;
        while (!done_w[k] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("b2b_lat%0d", k), 128'(cyc), 128'(b + 1));
        check($sformatf("b2b_res1_%0d", k), so_w[k], ref_sub(s1));
        @(posedge clk); #1;
        st[k] = 1'b0;
        cyc  = 1;
        held = 0;
        while (!done_w[k] && cyc < 40) begin
            if (so_w[k] !== ref_sub(s1)) held++;
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("b2b_gap%0d", k), 128'(cyc), 128'(b + 2));
        check($sformatf("b2b_held%0d", k), 128'(held), 128'd0);
        check($sformatf("b2b_res2_%0d", k), so_w[k], ref_sub(s2));
    endtask

    initial begin
        int extra;
        reset = 1'b1;
        st    = '0;
        sin   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_busy%0d", k), 128'(busy_w[k]), 128'd0);
            check($sformatf("rst_done%0d", k), 128'(done_w[k]), 128'd0);
            check($sformatf("rst_out%0d", k), so_w[k], 128'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        run_op(0, C1_IN, 1'b0);
        check("c1_kat", so_w[0], C1_OUT);
        for (int k = 0; k < 3; k++) begin
            run_op(k, C2_IN, 1'b0);
            check($sformatf("c2_kat%0d", k), so_w[k], C2_OUT);
        end

        b2b(0, C1_IN, C2_IN);
        b2b(1, C1_IN, C2_IN);
        b2b(2, C2_IN, C1_IN);

        run_op(0, C1_IN, 1'b1);
        check("noise_kat", so_w[0], C1_OUT);

        @(negedge clk);
        sin   = C2_IN;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 128'(busy_w[0]), 128'd0);
        check("mid_rst_done", 128'(done_w[0]), 128'd0);
        check("mid_rst_out", so_w[0], 128'd0);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done_w[0]) extra++;
        end
        check("mid_rst_pulses", 128'(extra), 128'd0);
        run_op(0, C1_IN, 1'b0);
        check("post_rst_kat", so_w[0], C1_OUT);

        run_op(0, '0, 1'b0);
        check("zero_kat0", so_w[0], {16{8'h63}});
        run_op(0, '1, 1'b0);
        check("ff_kat0", so_w[0], {16{8'h16}});
        run_op(2, '0, 1'b0);
        check("zero_kat2", so_w[2], {16{8'h63}});
        run_op(2, '1, 1'b0);
        check("ff_kat2", so_w[2], {16{8'h16}});

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 10; n++) begin
                run_op(k, rand128(), 1'(n % 3 == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
